dram_responder: RTL and testbench

Memory-side responder for the layer engines' DRAM request interface. It accepts one read and one write request per cycle from the active engine (relu, conv, pool) and holds the word array for the parameter, bias and feature-map regions. It returns read data through a fixed-latency pipeline with a valid strobe. It sits between the engine mux and the on-chip storage, and doubles as the bench's DRAM.

---
 rtl/dram_pkg.sv | 22 ++
 rtl/dram_rd_pipe.sv | 43 ++++
 rtl/dram_responder.sv | 93 +++++++++
 tb/tb_dram_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM responder and the engine mux.
// Region bases, default widths, request record and a saturating counter helper.
package dram_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 18;

    localparam int unsigned PARAM_BASE = 0;
    localparam int unsigned BIAS_BASE  = 61440;
    localparam int unsigned FMAP_BASE  = 131072;

    typedef struct packed {
        logic                      en;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } dram_req_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Fixed-depth read response pipeline: valid/data shift register.
// A stage only loads data when the stage before it is valid, so bubbles keep the last word.
module dram_rd_pipe
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [RD_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            if (i_vld) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_vld  = r_vld[RD_LATENCY-1];
    assign o_data = r_dat[RD_LATENCY-1];

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder: word array, same-address collision handling, request counters, sticky error.
// Define DRAM_WR_FWD_EN for write-first collisions; otherwise a colliding read returns the old word.
module dram_responder
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_WORDS  = 262144,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  err,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);

    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic                  r_err;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_wr_cnt;

    logic                  w_rd_inr;
    logic                  w_wr_inr;
    logic [MEM_AW-1:0]     w_rd_idx;
    logic [MEM_AW-1:0]     w_wr_idx;
    logic [DATA_WIDTH-1:0] w_fetch;

    assign w_rd_inr = {1'b0, rd_addr} < LIMIT;
    assign w_wr_inr = {1'b0, wr_addr} < LIMIT;
    assign w_rd_idx = rd_addr[MEM_AW-1:0];
    assign w_wr_idx = wr_addr[MEM_AW-1:0];

`ifdef DRAM_WR_FWD_EN
    logic w_hit;
    assign w_hit   = wr_en && w_wr_inr && (wr_addr == rd_addr);
    assign w_fetch = !w_rd_inr ? '0 : (w_hit ? wr_data : r_mem[w_rd_idx]);
`else
    assign w_fetch = !w_rd_inr ? '0 : r_mem[w_rd_idx];
`endif

    // Array is deliberately not reset; writes are ignored while held in reset.
    always_ff @(posedge clk) begin
        if (srstn && wr_en && w_wr_inr) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if ((rd_en && !w_rd_inr) || (wr_en && !w_wr_inr)) begin
                r_err <= 1'b1;
            end
            if (rd_en) begin
                r_rd_cnt <= sat_inc(r_rd_cnt);
            end
            if (wr_en) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end
        end
    end

    dram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .srstn  (srstn),
        .i_vld  (rd_en),
        .i_data (w_fetch),
        .o_vld  (rd_valid),
        .o_data (rd_data)
    );

    assign err    = r_err;
    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: three instances share one request stream
// (latency 1 full size, latency 3 full size, latency 4 half size with its own reset).
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        srstn, srstn_b;
    logic        rd_en, wr_en;
    logic [17:0] rd_addr, wr_addr;
    logic [31:0] wr_data;

    logic [31:0] a_rd_data, b_rd_data, c_rd_data;
    logic        a_rd_valid, b_rd_valid, c_rd_valid;
    logic        a_err, b_err, c_err;
    logic [31:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt, c_rd_cnt, c_wr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dram_responder #(.RD_LATENCY(1)) dut_a (
        .clk(clk), .srstn(srstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .err(a_err), .rd_cnt(a_rd_cnt), .wr_cnt(a_wr_cnt)
    );

    dram_responder #(.RD_LATENCY(4), .MEM_WORDS(131072)) dut_b (
        .clk(clk), .srstn(srstn_b), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .err(b_err), .rd_cnt(b_rd_cnt), .wr_cnt(b_wr_cnt)
    );

    dram_responder #(.RD_LATENCY(3)) dut_c (
        .clk(clk), .srstn(srstn), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .err(c_err), .rd_cnt(c_rd_cnt), .wr_cnt(c_wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there after each tick.
    task automatic cyc(input logic re, input logic [17:0] ra, input logic we,
                       input logic [17:0] wa, input logic [31:0] wd);
        rd_en   = re;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 18'd0, 1'b0, 18'd0, 32'd0);
    endtask

    initial begin
        srstn   = 1'b0;
        srstn_b = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) @(negedge clk);

        chk("rst_a_valid", a_rd_valid, 0);
        chk("rst_a_data",  a_rd_data,  0);
        chk("rst_a_err",   a_err,      0);
        chk("rst_a_rdcnt", a_rd_cnt,   0);
        chk("rst_a_wrcnt", a_wr_cnt,   0);
        chk("rst_b_valid", b_rd_valid, 0);

        srstn = 1'b1;
        idle();

        // write then read one cycle later
        cyc(1'b0, 18'd0, 1'b1, 18'd131072, 32'd5);
        cyc(1'b1, 18'd131072, 1'b0, 18'd0, 32'd0);
        chk("wr_rd_valid", a_rd_valid, 1);
        chk("wr_rd_data",  a_rd_data,  5);
        chk("wr_rd_rdcnt", a_rd_cnt,   1);
        chk("wr_rd_wrcnt", a_wr_cnt,   1);
        idle();
        chk("bubble_valid", a_rd_valid, 0);
        chk("bubble_hold",  a_rd_data,  5);

        // preload bias region with index, then stream reads without gaps
        for (int i = 0; i < 16; i++) cyc(1'b0, 18'd0, 1'b1, 18'(61440 + i), 32'(i));
        for (int i = 0; i < 19; i++) begin
            cyc(i < 16, 18'(61440 + i), 1'b0, 18'd0, 32'd0);
            chk("stream_a_valid", a_rd_valid, 32'(i < 16));
            if (i < 16) chk("stream_a_data", a_rd_data, 32'(i));
            chk("stream_c_valid", c_rd_valid, 32'(i >= 2 && i < 18));
            if (i >= 2 && i < 18) chk("stream_c_data", c_rd_data, 32'(i - 2));
        end
        chk("stream_a_hold",  a_rd_data, 15);
        chk("stream_a_rdcnt", a_rd_cnt,  17);
        chk("stream_a_wrcnt", a_wr_cnt,  17);

        // same-cycle collision, then read-write-read of one address
        cyc(1'b0, 18'd0, 1'b1, 18'd131073, 32'h11);
        cyc(1'b1, 18'd131073, 1'b1, 18'd131073, 32'h22);
        chk("coll_valid", a_rd_valid, 1);
`ifdef DRAM_WR_FWD_EN
        chk("coll_data", a_rd_data, 32'h22);
`else
        chk("coll_data", a_rd_data, 32'h11);
`endif
        cyc(1'b1, 18'd131073, 1'b0, 18'd0, 32'd0);
        chk("coll_after", a_rd_data, 32'h22);
        cyc(1'b0, 18'd0, 1'b1, 18'd131073, 32'h44);
        cyc(1'b1, 18'd131073, 1'b0, 18'd0, 32'd0);
        chk("rwr_data", a_rd_data, 32'h44);
        idle();

        // half-size instance: requests while in reset were ignored
        srstn_b = 1'b1;
        idle();
        chk("b_rel_rdcnt", b_rd_cnt,   0);
        chk("b_rel_wrcnt", b_wr_cnt,   0);
        chk("b_rel_err",   b_err,      0);
        chk("b_rel_valid", b_rd_valid, 0);

        cyc(1'b0, 18'd0, 1'b1, 18'd100, 32'hABCD);
        cyc(1'b0, 18'd0, 1'b1, 18'd131071, 32'h1234);
        cyc(1'b1, 18'd100, 1'b0, 18'd0, 32'd0);
        chk("oor_err_pre", b_err, 0);
        cyc(1'b1, 18'd262143, 1'b0, 18'd0, 32'd0);
        chk("oor_err_set", b_err, 1);
        idle();
        idle();
        chk("oor_prev_valid", b_rd_valid, 1);
        chk("oor_prev_data",  b_rd_data,  32'hABCD);
        idle();
        chk("oor_valid", b_rd_valid, 1);
        chk("oor_data",  b_rd_data,  0);
        idle();
        chk("oor_done_valid", b_rd_valid, 0);

        // out-of-range write must not alias onto the top word
        cyc(1'b0, 18'd0, 1'b1, 18'd262143, 32'h77);
        cyc(1'b1, 18'd131071, 1'b0, 18'd0, 32'd0);
        idle();
        idle();
        idle();
        chk("oorw_valid", b_rd_valid, 1);
        chk("oorw_data",  b_rd_data,  32'h1234);
        chk("oorw_err",   b_err,      1);
        chk("oorw_rdcnt", b_rd_cnt,   3);
        chk("oorw_wrcnt", b_wr_cnt,   3);

        // reset with three reads in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 18'd100, 1'b0, 18'd0, 32'd0);
        srstn_b = 1'b0;
        idle();
        srstn_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("rst_flush_valid", b_rd_valid, 0);
        end
        chk("rst_rdcnt", b_rd_cnt,  0);
        chk("rst_wrcnt", b_wr_cnt,  0);
        chk("rst_err",   b_err,     0);
        chk("rst_data",  b_rd_data, 0);
        cyc(1'b1, 18'd100, 1'b0, 18'd0, 32'd0);
        idle();
        idle();
        chk("rst_keep_pre", b_rd_valid, 0);
        idle();
        chk("rst_keep_valid", b_rd_valid, 1);
        chk("rst_keep_data",  b_rd_data,  32'hABCD);
        chk("rst_keep_rdcnt", b_rd_cnt,   1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
